// File: rtl/ship_heading.sv
// ship_heading -- rotating heading controller for a ship sprite.
//
// A free-running tick counter paces rotation updates at DIVIDER Hz. On each tick the
// left/right buttons rotate the 10-bit phase. The phase moves slowly at first and
// speeds up after HOLD_TICKS consecutive ticks in the same direction. A collision
// restarts the heading immediately.
//
// Ports:
//   clk        system clock, rising edge
//   resetN     asynchronous active-low reset
//   left       rotate counter-clockwise (phase increases)
//   right      rotate clockwise (phase decreases)
//   collision  synchronous restart request, overrides tick and buttons
//   phase      registered 10-bit heading for the sine/cosine table
//   frame_idx  registered sprite orientation index, nearest of 16
//   rotating   registered, high while the FSM is not idle
module ship_heading #(
   parameter int unsigned CLK_RATE   = 25_000_000,
   parameter int unsigned DIVIDER    = 60,
   parameter int unsigned SLOW_STEP  = 4,
   parameter int unsigned FAST_STEP  = 16,
   parameter int unsigned HOLD_TICKS = 8,
   parameter logic [9:0]  INIT_PHASE = 10'd0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       left,
   input  logic       right,
   input  logic       collision,
   output logic [9:0] phase,
   output logic [3:0] frame_idx,
   output logic       rotating
);

   localparam int unsigned TickPeriod = CLK_RATE / DIVIDER;
   localparam int unsigned CntW       = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TickPeriod - 1);

   // One spare bit so the incremented hold count can never wrap.
   localparam int unsigned HoldW = $clog2(HOLD_TICKS + 2);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS);
   localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

   localparam logic [9:0] SlowInc = 10'(SLOW_STEP);
   localparam logic [9:0] FastInc = 10'(FAST_STEP);

   // Adding half a sector (32) before truncating rounds to the nearest orientation.
   localparam logic [9:0] InitFrameSum = INIT_PHASE + 10'd32;
   localparam logic [3:0] InitFrame    = InitFrameSum[9:6];

   typedef enum logic [1:0] {
      StIdle,
      StSlow,
      StFast
   } state_e;

   logic [CntW-1:0]  cnt_q;
   logic             tick;
   state_e           state_q, state_d;
   logic             dir_q, dir_d;     // 0: left (increasing), 1: right (decreasing)
   logic [HoldW-1:0] hold_q, hold_d;
   logic [HoldW-1:0] hold_inc;
   logic [9:0]       phase_q, phase_d;
   logic [9:0]       step;
   logic [9:0]       frame_sum;
   logic [3:0]       frame_q;
   logic             rotating_q;
   logic             req_valid;
   logic             req_dir;

   //------------------------------------------------------------------
   // Tick counter: collision deliberately does not touch it.
   //------------------------------------------------------------------
   assign tick = (cnt_q == CntLast);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   //------------------------------------------------------------------
   // Rotation FSM
   //------------------------------------------------------------------
   assign req_valid = left ^ right;
   assign req_dir   = right;
   assign hold_inc  = hold_q + HoldOne;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      phase_d = phase_q;
      step    = SlowInc;

      if (collision) begin
         phase_d = INIT_PHASE;
         state_d = StIdle;
         hold_d  = '0;
      end else if (tick) begin
         if (!req_valid) begin
            state_d = StIdle;
            hold_d  = '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  dir_d   = req_dir;
                  hold_d  = HoldOne;
                  state_d = StSlow;
               end
               StSlow: begin
                  if (req_dir == dir_q) begin
                     hold_d  = hold_inc;
                     // >= rather than == keeps HOLD_TICKS = 1 from stalling in SLOW.
                     state_d = (hold_inc >= HoldLast) ? StFast : StSlow;
                  end else begin
                     dir_d   = req_dir;
                     hold_d  = HoldOne;
                     state_d = StSlow;
                  end
               end
               StFast: begin
                  if (req_dir == dir_q) begin
                     step = FastInc;
                  end else begin
                     dir_d   = req_dir;
                     hold_d  = HoldOne;
                     state_d = StSlow;
                  end
               end
               default: begin
                  state_d = StIdle;
                  hold_d  = '0;
               end
            endcase
            // Modulo-1024 wrap comes for free from the 10-bit width.
            phase_d = req_dir ? (phase_q - step) : (phase_q + step);
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= StIdle;
         dir_q   <= 1'b0;
         hold_q  <= '0;
         phase_q <= INIT_PHASE;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
         phase_q <= phase_d;
      end
   end

   //------------------------------------------------------------------
   // Output registers
   //------------------------------------------------------------------
   assign frame_sum = phase_q + 10'd32;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frame_q    <= InitFrame;
         rotating_q <= 1'b0;
      end else begin
         frame_q    <= frame_sum[9:6];
         rotating_q <= (state_d != StIdle);
      end
   end

   assign phase     = phase_q;
   assign frame_idx = frame_q;
   assign rotating  = rotating_q;

endmodule

// File: tb/tb_ship_heading.sv
// tb_ship_heading -- self-checking bench for ship_heading with a tick every 2 cycles.
//
// The reference model describes rotation in terms of run length: the number of
// consecutive ticks requesting the same direction. Runs longer than HOLD_TICKS use
// the fast step; a direction change restarts the run; an empty tick or a collision
// ends it.
module tb_ship_heading;

   localparam int P     = 2;     // CLK_RATE / DIVIDER
   localparam int SLOW  = 4;
   localparam int FAST  = 16;
   localparam int HOLD  = 8;
   localparam int INIT  = 0;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       left = 1'b0;
   logic       right = 1'b0;
   logic       collision = 1'b0;
   logic [9:0] phase;
   logic [3:0] frame_idx;
   logic       rotating;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_phase;
   int m_frame;
   int run_len;
   int run_dir;
   int edge_n;

   ship_heading #(
      .CLK_RATE (4),
      .DIVIDER  (2)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .left      (left),
      .right     (right),
      .collision (collision),
      .phase     (phase),
      .frame_idx (frame_idx),
      .rotating  (rotating)
   );

   always #5 clk = ~clk;

   // Assert reset between clock edges; model takes its reset values at once.
   task automatic assert_reset();
      #3;
      resetN    = 1'b0;
      left      = 1'b0;
      right     = 1'b0;
      collision = 1'b0;
      m_phase   = INIT;
      m_frame   = ((INIT + 32) % 1024) / 64;
      run_len   = 0;
      run_dir   = 0;
      edge_n    = 0;
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   // One clock: apply inputs, advance the model across the edge, settle #1 after it.
   task automatic drive(input bit l, input bit r, input bit c);
      int prev;
      int d;
      int stp;
      bit is_tick;
      left      = l;
      right     = r;
      collision = c;
      @(posedge clk);
      is_tick = ((edge_n % P) == P - 1);
      edge_n++;
      prev = m_phase;
      if (c) begin
         m_phase = INIT;
         run_len = 0;
      end else if (is_tick) begin
         if (l != r) begin
            d = l ? 1 : -1;
            if (run_len > 0 && d == run_dir) begin
               if (run_len <= HOLD) run_len++;
            end else begin
               run_len = 1;
               run_dir = d;
            end
            stp = (run_len > HOLD) ? FAST : SLOW;
            m_phase = (m_phase + 1024 + d * stp) % 1024;
         end else begin
            run_len = 0;
         end
      end
      m_frame = ((prev + 32) % 1024) / 64;
      #1;
   endtask

   task automatic drive_ticks(input bit l, input bit r, input int n);
      for (int i = 0; i < n * P; i++) drive(l, r, 1'b0);
   endtask

   task automatic test_reset();
      assert_reset();
      checks++;
      if (phase !== 10'(INIT)) begin
         errors++; $display("FAIL reset_phase got %0d want %0d", phase, INIT);
      end
      checks++;
      if (frame_idx !== 4'd0) begin
         errors++; $display("FAIL reset_frame got %0d want 0", frame_idx);
      end
      checks++;
      if (rotating !== 1'b0) begin
         errors++; $display("FAIL reset_rotating got %0b want 0", rotating);
      end
      release_reset();
      for (int i = 0; i < 3 * P; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         checks++;
         if (phase !== 10'd0 || frame_idx !== 4'd0 || rotating !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got phase=%0d frame=%0d rot=%0b want 0/0/0",
                     phase, frame_idx, rotating);
         end
      end
   endtask

   task automatic test_left_slow();
      int want;
      assert_reset();
      release_reset();
      for (int t = 1; t <= 3; t++) begin
         drive(1'b1, 1'b0, 1'b0);  // non-tick cycle
         drive(1'b1, 1'b0, 1'b0);  // tick cycle
         want = 4 * t;
         checks++;
         if (phase !== 10'(want) || rotating !== 1'b1 || frame_idx !== 4'd0) begin
            errors++;
            $display("FAIL left_slow tick%0d got phase=%0d rot=%0b frame=%0d want %0d/1/0",
                     t, phase, rotating, frame_idx, want);
         end
      end
   endtask

   task automatic test_right_wrap();
      assert_reset();
      release_reset();
      drive_ticks(1'b0, 1'b1, 1);
      checks++;
      if (phase !== 10'd1020 || rotating !== 1'b1) begin
         errors++;
         $display("FAIL right_wrap got phase=%0d rot=%0b want 1020/1", phase, rotating);
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (frame_idx !== 4'd0) begin
         errors++; $display("FAIL right_wrap_frame got %0d want 0", frame_idx);
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (phase !== 10'd1020 || rotating !== 1'b0) begin
         errors++;
         $display("FAIL right_release got phase=%0d rot=%0b want 1020/0", phase, rotating);
      end
   endtask

   task automatic test_fast();
      assert_reset();
      release_reset();
      drive_ticks(1'b1, 1'b0, 8);
      checks++;
      if (phase !== 10'd32) begin
         errors++; $display("FAIL fast_tick8 got %0d want 32", phase);
      end
      drive_ticks(1'b1, 1'b0, 2);
      checks++;
      if (phase !== 10'd64) begin
         errors++; $display("FAIL fast_tick10 got %0d want 64", phase);
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++;
      if (frame_idx !== 4'd1) begin
         errors++; $display("FAIL fast_frame got %0d want 1", frame_idx);
      end
   endtask

   task automatic test_both_then_reverse();
      assert_reset();
      release_reset();
      drive_ticks(1'b1, 1'b1, 4);
      checks++;
      if (phase !== 10'd0 || rotating !== 1'b0) begin
         errors++;
         $display("FAIL both_pressed got phase=%0d rot=%0b want 0/0", phase, rotating);
      end
      drive_ticks(1'b1, 1'b0, 10);
      checks++;
      if (phase !== 10'd64) begin
         errors++; $display("FAIL reverse_setup got %0d want 64", phase);
      end
      drive_ticks(1'b0, 1'b1, 1);
      checks++;
      if (phase !== 10'd60 || rotating !== 1'b1) begin
         errors++;
         $display("FAIL reverse_step got phase=%0d rot=%0b want 60/1", phase, rotating);
      end
      // A second right tick must still be a slow step.
      drive_ticks(1'b0, 1'b1, 1);
      checks++;
      if (phase !== 10'd56) begin
         errors++; $display("FAIL reverse_slow got %0d want 56", phase);
      end
   endtask

   task automatic test_collision();
      assert_reset();
      release_reset();
      drive_ticks(1'b1, 1'b0, 2);     // 8
      drive_ticks(1'b0, 1'b0, 1);     // idle
      drive_ticks(1'b1, 1'b0, 18);    // 8 slow + 10 fast -> 200
      checks++;
      if (phase !== 10'd200 || rotating !== 1'b1) begin
         errors++;
         $display("FAIL collision_setup got phase=%0d rot=%0b want 200/1", phase, rotating);
      end
      drive(1'b1, 1'b0, 1'b0);        // non-tick
      drive(1'b1, 1'b0, 1'b1);        // tick cycle with collision
      checks++;
      if (phase !== 10'(INIT) || rotating !== 1'b0) begin
         errors++;
         $display("FAIL collision got phase=%0d rot=%0b want 0/0", phase, rotating);
      end
      drive_ticks(1'b1, 1'b0, 1);
      checks++;
      if (phase !== 10'd4 || rotating !== 1'b1) begin
         errors++;
         $display("FAIL after_collision got phase=%0d rot=%0b want 4/1", phase, rotating);
      end
   endtask

   task automatic test_random();
      bit l;
      bit r;
      bit c;
      assert_reset();
      release_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            assert_reset();
            checks++;
            if (phase !== 10'(m_phase) || frame_idx !== 4'(m_frame) || rotating !== 1'b0) begin
               errors++;
               $display("FAIL rand_reset got phase=%0d frame=%0d rot=%0b want %0d/%0d/0",
                        phase, frame_idx, rotating, m_phase, m_frame);
            end
            release_reset();
         end
         // Bias toward long holds so FAST is reached regularly.
         if ($urandom_range(0, 7) == 0) begin
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
         end else begin
            l = left;
            r = right;
            if (!l && !r) l = 1'b1;
         end
         c = ($urandom_range(0, 63) == 0);
         drive(l, r, c);
         checks++;
         if (phase !== 10'(m_phase) || frame_idx !== 4'(m_frame) ||
             rotating !== (run_len != 0)) begin
            errors++;
            $display("FAIL rand_cycle%0d got phase=%0d frame=%0d rot=%0b want %0d/%0d/%0b",
                     i, phase, frame_idx, rotating, m_phase, m_frame, (run_len != 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_left_slow();
      test_right_wrap();
      test_fast();
      test_both_then_reverse();
      test_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ship_heading.md
SHIP_HEADING -- requirements
Module: ship_heading

Interface
REQ-001 Parameter CLK_RATE, default 25_000_000, system clock frequency in Hz.
REQ-002 Parameter DIVIDER, default 60, rotation update rate in Hz; tick period is CLK_RATE/DIVIDER cycles, minimum 2.
REQ-003 Parameter SLOW_STEP, default 4, phase increment per tick in SLOW state.
REQ-004 Parameter FAST_STEP, default 16, phase increment per tick in FAST state.
REQ-005 Parameter HOLD_TICKS, default 8, number of SLOW ticks before entering FAST, minimum 1.
REQ-006 Parameter INIT_PHASE, default 0, 10-bit phase loaded on reset and on collision.
REQ-007 Port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-008 Port resetN, input, 1, asynchronous active-low reset.
REQ-009 Port left, input, 1, rotate counter-clockwise (phase increases); already synchronized upstream.
REQ-010 Port right, input, 1, rotate clockwise (phase decreases); already synchronized upstream.
REQ-011 Port collision, input, 1, synchronous restart request.
REQ-012 Port phase, output, 10, registered heading; drives the phase input of the sine/cosine table that feeds ship motion.
REQ-013 Port frame_idx, output, 4, registered sprite orientation index.
REQ-014 Port rotating, output, 1, registered; high when state is not IDLE.

Function
REQ-015 The tick counter SHALL count 0..CLK_RATE/DIVIDER-1 and wrap to 0.
- The internal tick pulse is high for exactly the one cycle in which the count is at its terminal value.
REQ-016 The FSM SHALL have the states IDLE, SLOW and FAST, plus a direction register dir and a hold counter hold_cnt.
- All state changes occur only in tick cycles, except collision.
REQ-017 In a tick cycle, a valid request SHALL mean exactly one of left or right is high. Both high or neither high is no request.
REQ-018 Tick in IDLE with a valid request:
- phase += SLOW_STEP (left) or -= SLOW_STEP (right);
- dir is latched;
- hold_cnt = 1;
- next state SLOW.
REQ-019 Tick in SLOW with a request in the same direction:
- phase steps by SLOW_STEP;
- hold_cnt increments;
- when the incremented value equals HOLD_TICKS, next state is FAST.
REQ-020 Tick in FAST with a request in the same direction SHALL step phase by FAST_STEP and stay in FAST.
REQ-021 Tick in SLOW or FAST with a request in the opposite direction:
- phase steps by SLOW_STEP in the new direction;
- dir updates;
- hold_cnt = 1;
- next state SLOW.
REQ-022 Tick in any state with no request: phase holds, hold_cnt = 0, next state IDLE.
REQ-023 Phase arithmetic SHALL be modulo 1024 with no saturation (for example, 1020 + 4 = 0 and 0 - 4 = 1020).
REQ-024 The phase output SHALL change on the clock edge that ends the tick cycle, giving 1-cycle latency from tick to output.
REQ-025 frame_idx SHALL be ((phase + 32) mod 1024) >> 6, registered from the phase register.
- It lags phase by 1 cycle.
- The rounding is to the nearest of 16 orientations.
REQ-026 Collision SHALL act on the next clock edge regardless of tick.
- phase = INIT_PHASE, state IDLE, hold_cnt = 0.
- The tick counter is not disturbed.
- Collision takes priority over a coincident tick and over any button input.
REQ-027 Non-tick cycles SHALL leave phase, state, dir and hold_cnt unchanged (collision excepted).

Reset
REQ-028 While resetN = 0, asynchronously and independent of clk:
- phase = INIT_PHASE;
- frame_idx = ((INIT_PHASE + 32) mod 1024) >> 6;
- rotating = 0;
- state IDLE, hold_cnt = 0, dir = 0, tick counter = 0.
REQ-029 Reset asserted mid-rotation (SLOW or FAST) SHALL immediately apply REQ-028.
- After release, the first tick occurs CLK_RATE/DIVIDER cycles after the first clock edge.

Verification
All scenarios use CLK_RATE=4 and DIVIDER=2 (tick every 2 cycles), with the other parameters at their defaults.
REQ-030 Reset pulse -> phase = 0, frame_idx = 0, rotating = 0 during reset and until the first tick carrying a request.
REQ-031 left held for 3 ticks from phase 0 -> phase reads 4, 8, 12 one cycle after each tick; rotating = 1; frame_idx = 0.
REQ-032 right held for 1 tick from phase 0 -> phase = 1020 (wrap), frame_idx = 0; release, next tick -> phase holds at 1020, rotating = 0.
REQ-033 left held for 10 ticks from phase 0 -> phase after tick 8 = 32 (state FAST), after tick 10 = 64; frame_idx = 1 one cycle after phase reaches 64.
REQ-034 left and right both high for 4 ticks -> phase unchanged, rotating = 0. Then switching from left in FAST to right -> next step is -4 and state is SLOW.
REQ-035 Collision asserted in a tick cycle while in FAST at phase 200 with left held -> phase = 0, rotating = 0 on the next edge; the following tick with left -> phase = 4.
